// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock, then
// releases downstream resets in ascending, staggered order and supervises lock.

module pll_reset_sequencer #(
    parameter int NUM_CHANNELS        = 4,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int STAGGER_CYCLES      = 8,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                    clk_in1,
    input  logic                    reset,
    input  logic                    pll_locked,
    input  logic                    restart,
    output logic                    pll_reset,
    output logic [NUM_CHANNELS-1:0] rst_out,
    output logic                    all_ready,
    output logic                    fail,
    output logic [7:0]              lock_lost_count
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int SPAN_CS = NUM_CHANNELS * STAGGER_CYCLES;
    localparam int MAX_CD  = (LOCK_STABLE_CYCLES > SPAN_CS) ? LOCK_STABLE_CYCLES : SPAN_CS;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int CH_W    = $clog2(NUM_CHANNELS) + 1;
    localparam int RT_W    = $clog2(MAX_RETRIES + 1) + 1;

    localparam logic [CNT_W-1:0]        CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]        PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]        TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]        STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]        STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CH_W-1:0]         LAST_CH      = CH_W'(NUM_CHANNELS - 1);
    localparam logic [RT_W-1:0]         RETRY_LIMIT  = RT_W'(MAX_RETRIES);
    localparam logic [NUM_CHANNELS-1:0] CH_ALL       = {NUM_CHANNELS{1'b1}};

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CH_W-1:0]         chan_q, chan_d;
    logic [RT_W-1:0]         retry_q, retry_d;
    logic                    pll_reset_q, pll_reset_d;
    logic [NUM_CHANNELS-1:0] rst_out_q, rst_out_d;
    logic                    all_ready_q, all_ready_d;
    logic                    fail_q, fail_d;
    logic [7:0]              lost_q, lost_d;
    logic                    meta_q, locked_q;
    logic                    lock_loss_s;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            meta_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            meta_q   <= pll_locked;
            locked_q <= meta_q;
        end
    end

    assign lock_loss_s = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !locked_q;

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chan_d      = chan_q;
        retry_d     = retry_q;
        pll_reset_d = pll_reset_q;
        rst_out_d   = rst_out_q;
        all_ready_d = all_ready_q;
        fail_d      = fail_q;
        lost_d      = lost_q;
        if (restart) begin
            state_d     = ST_PLL_RST;
            cnt_d       = CNT_ZERO;
            chan_d      = {CH_W{1'b0}};
            retry_d     = {RT_W{1'b0}};
            pll_reset_d = 1'b1;
            rst_out_d   = CH_ALL;
            all_ready_d = 1'b0;
            fail_d      = 1'b0;
        end else if (lock_loss_s) begin
            state_d     = ST_PLL_RST;
            cnt_d       = CNT_ZERO;
            chan_d      = {CH_W{1'b0}};
            retry_d     = {RT_W{1'b0}};
            pll_reset_d = 1'b1;
            rst_out_d   = CH_ALL;
            all_ready_d = 1'b0;
            if (lost_q != 8'hFF) begin
                lost_d = lost_q + 8'd1;
            end else begin
                lost_d = lost_q;
            end
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    pll_reset_d = 1'b1;
                    if (cnt_q == PLL_LAST) begin
                        state_d     = ST_WAIT_LOCK;
                        cnt_d       = CNT_ZERO;
                        pll_reset_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d       = CNT_ZERO;
                        pll_reset_d = 1'b1;
                        if (retry_q == RETRY_LIMIT) begin
                            state_d = ST_FAIL;
                            fail_d  = 1'b1;
                        end else begin
                            state_d = ST_PLL_RST;
                            retry_d = retry_q + RT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!locked_q) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == STABLE_LAST) begin
                        cnt_d        = CNT_ZERO;
                        chan_d       = CH_W'(1);
                        rst_out_d[0] = 1'b0;
                        if (NUM_CHANNELS == 1) begin
                            state_d     = ST_RUN;
                            all_ready_d = 1'b1;
                            retry_d     = {RT_W{1'b0}};
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == STAGGER_LAST) begin
                        cnt_d  = CNT_ZERO;
                        chan_d = chan_q + CH_W'(1);
                        for (int k = 0; k < NUM_CHANNELS; k++) begin
                            if (CH_W'(k) == chan_q) begin
                                rst_out_d[k] = 1'b0;
                            end else begin
                                rst_out_d[k] = rst_out_q[k];
                            end
                        end
                        if (chan_q == LAST_CH) begin
                            state_d     = ST_RUN;
                            all_ready_d = 1'b1;
                            retry_d     = {RT_W{1'b0}};
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    retry_d = {RT_W{1'b0}};
                end
                ST_FAIL: begin
                    pll_reset_d = 1'b1;
                    rst_out_d   = CH_ALL;
                    all_ready_d = 1'b0;
                    fail_d      = 1'b1;
                end
                default: begin
                    state_d     = ST_PLL_RST;
                    cnt_d       = CNT_ZERO;
                    chan_d      = {CH_W{1'b0}};
                    retry_d     = {RT_W{1'b0}};
                    pll_reset_d = 1'b1;
                    rst_out_d   = CH_ALL;
                    all_ready_d = 1'b0;
                    fail_d      = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset forces every channel back into reset at once.
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= CNT_ZERO;
            chan_q      <= {CH_W{1'b0}};
            retry_q     <= {RT_W{1'b0}};
            pll_reset_q <= 1'b1;
            rst_out_q   <= CH_ALL;
            all_ready_q <= 1'b0;
            fail_q      <= 1'b0;
            lost_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chan_q      <= chan_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            rst_out_q   <= rst_out_d;
            all_ready_q <= all_ready_d;
            fail_q      <= fail_d;
            lost_q      <= lost_d;
        end
    end

    assign pll_reset       = pll_reset_q;
    assign rst_out         = rst_out_q;
    assign all_ready       = all_ready_q;
    assign fail            = fail_q;
    assign lock_lost_count = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a 4-channel default instance and a 1-channel,
// 1-cycle-stagger instance driven by the same lock waveform, checked cycle by cycle.

module tb_pll_reset_sequencer;

    localparam int INF  = 1 << 30;
    localparam int PMAX = 25000;
    localparam int TO_PERIOD = 16 + 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       restart;

    logic       pll_reset_a, all_ready_a, fail_a;
    logic [3:0] rst_out_a;
    logic [7:0] lost_a;
    logic       pll_reset_b, all_ready_b, fail_b;
    logic [0:0] rst_out_b;
    logic [7:0] lost_b;

    int checks   = 0;
    int failures = 0;

    // p[n]: pll_locked level driven ahead of edge n (n = 1 is the first edge after reset release)
    bit p [0:PMAX-1];
    // Model events: r1/r2 = edges entering RELEASE, xl = edge that acts on a lock loss
    int r1, xl, r2;
    int fall0, fall3, rdy_rise, pll_fall, low_b;

    pll_reset_sequencer dut_a (
        .clk_in1(clk), .reset(reset), .pll_locked(pll_locked), .restart(restart),
        .pll_reset(pll_reset_a), .rst_out(rst_out_a), .all_ready(all_ready_a),
        .fail(fail_a), .lock_lost_count(lost_a)
    );

    pll_reset_sequencer #(.NUM_CHANNELS(1), .STAGGER_CYCLES(1)) dut_b (
        .clk_in1(clk), .reset(reset), .pll_locked(pll_locked), .restart(restart),
        .pll_reset(pll_reset_b), .rst_out(rst_out_b), .all_ready(all_ready_b),
        .fail(fail_b), .lock_lost_count(lost_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic fill(input int from, input int to, input bit v);
        for (int i = from; i <= to; i++) p[i] = v;
    endtask

    // Lock level the sequencer decides on at edge n (two-flop delay, flops cleared by reset).
    function automatic bit lk(input int n);
        return (n >= 2) ? p[n-2] : 1'b0;
    endfunction

    // Release happens at the first edge r whose 65 most recent decision samples
    // (the STABLE entry sample plus 64 stable ones) are all locked, all after WAIT_LOCK entry w.
    function automatic int window_release(input int w);
        bit ok;
        for (int r = w + 65; r < PMAX; r++) begin
            ok = 1'b1;
            for (int j = r - 64; j <= r; j++) begin
                if (!lk(j)) ok = 1'b0;
            end
            if (ok) return r;
        end
        return INF;
    endfunction

    function automatic logic [3:0] exp_rst(input int n, input int nch, input int stg);
        logic [3:0] v;
        v = 4'b0000;
        for (int k = 0; k < nch; k++) begin
            v[k] = !((n >= r1 + k * stg && n < xl) || (n >= r2 + k * stg));
        end
        return v;
    endfunction

    function automatic logic exp_ready(input int n, input int nch, input int stg);
        return (n >= r1 + (nch - 1) * stg && n < xl) || (n >= r2 + (nch - 1) * stg);
    endfunction

    function automatic logic exp_pll(input int n);
        return (n < 16) || (n >= xl && n < xl + 16);
    endfunction

    task automatic run_trial(input int len);
        fall0 = INF; fall3 = INF; rdy_rise = INF; pll_fall = INF; low_b = 0;
        @(negedge clk);
        reset = 1'b1; restart = 1'b0; pll_locked = 1'b0;
        #1;
        chk("reset_pll_reset", 0, 32'(pll_reset_a), 32'd1);
        chk("reset_rst_out_a", 0, 32'(rst_out_a), 32'hF);
        chk("reset_all_ready", 0, 32'(all_ready_a), 32'd0);
        chk("reset_fail", 0, 32'(fail_a), 32'd0);
        chk("reset_lost", 0, 32'(lost_a), 32'd0);
        chk("reset_rst_out_b", 0, 32'(rst_out_b), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        pll_locked = p[1];
        for (int n = 1; n <= len; n++) begin
            @(negedge clk);
            chk("a_rst_out", n, 32'(rst_out_a), 32'(exp_rst(n, 4, 8)));
            chk("a_all_ready", n, 32'(all_ready_a), 32'(exp_ready(n, 4, 8)));
            chk("a_pll_reset", n, 32'(pll_reset_a), 32'(exp_pll(n)));
            chk("a_lost", n, 32'(lost_a), (n >= xl) ? 32'd1 : 32'd0);
            chk("a_fail", n, 32'(fail_a), 32'd0);
            chk("b_rst_out", n, 32'(rst_out_b), 32'(exp_rst(n, 1, 1)));
            chk("b_all_ready", n, 32'(all_ready_b), 32'(exp_ready(n, 1, 1)));
            chk("b_pll_reset", n, 32'(pll_reset_b), 32'(exp_pll(n)));
            chk("b_lost", n, 32'(lost_b), (n >= xl) ? 32'd1 : 32'd0);
            if (fall0 == INF && rst_out_a[0] == 1'b0) fall0 = n;
            if (fall3 == INF && rst_out_a[3] == 1'b0) fall3 = n;
            if (rdy_rise == INF && all_ready_a == 1'b1) rdy_rise = n;
            if (pll_fall == INF && pll_reset_a == 1'b0) pll_fall = n;
            if (n <= 150 && rst_out_b[0] == 1'b0) low_b++;
            pll_locked = p[n+1];
        end
    endtask

    initial begin
        int t_on, ng, g, gl, d, dl, last;
        reset = 1'b1; restart = 1'b0; pll_locked = 1'b0;

        // Lock tied high: nominal release timing.
        fill(0, PMAX - 1, 1'b1); p[0] = 1'b0;
        r1 = window_release(16); xl = INF; r2 = INF;
        run_trial(130);
        chk("nominal_pll_fall", 0, 32'(pll_fall), 32'd16);
        chk("nominal_ch0_fall", 0, 32'(fall0), 32'd81);
        chk("nominal_ch3_fall", 0, 32'(fall3), 32'd105);
        chk("nominal_ready_rise", 0, 32'(rdy_rise), 32'd105);

        // One-cycle dropout 30 cycles into STABLE.
        fill(0, PMAX - 1, 1'b1); p[0] = 1'b0; p[45] = 1'b0;
        r1 = window_release(16); xl = INF; r2 = INF;
        run_trial(140);
        chk("stable_glitch_ch0_fall", 0, 32'(fall0), 32'd112);
        chk("stable_glitch_lost", 0, 32'(lost_a), 32'd0);

        // Five-cycle lock loss in RUN.
        fill(0, PMAX - 1, 1'b1); p[0] = 1'b0; fill(120, 124, 1'b0);
        r1 = window_release(16); xl = 120 + 2; r2 = window_release(xl + 16);
        run_trial(240);
        chk("run_loss_lost", 0, 32'(lost_a), 32'd1);

        // Lock loss seen on the edge right after RELEASE entry.
        fill(0, PMAX - 1, 1'b1); p[0] = 1'b0; p[80] = 1'b0;
        r1 = window_release(16); xl = 80 + 2; r2 = window_release(xl + 16);
        run_trial(200);
        chk("entry_loss_low_cycles_b", 0, 32'(low_b), 32'd1);
        chk("entry_loss_lost_b", 0, 32'(lost_b), 32'd1);

        // Reset asserted mid-RELEASE must reassert channels before any clock edge.
        fill(0, PMAX - 1, 1'b1); p[0] = 1'b0;
        r1 = window_release(16); xl = INF; r2 = INF;
        run_trial(92);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_rst_out_a", 92, 32'(rst_out_a), 32'hF);
        chk("async_reset_ready_a", 92, 32'(all_ready_a), 32'd0);
        chk("async_reset_rst_out_b", 92, 32'(rst_out_b), 32'd1);
        chk("async_reset_ready_b", 92, 32'(all_ready_b), 32'd0);

        // Randomised acquisition with STABLE glitches and optional later lock loss.
        repeat (6) begin
            fill(0, PMAX - 1, 1'b0);
            t_on = $urandom_range(300, 1);
            fill(t_on, PMAX - 1, 1'b1);
            ng = $urandom_range(3, 0);
            for (int i = 0; i < ng; i++) begin
                g  = t_on + $urandom_range(60, 0);
                gl = $urandom_range(3, 1);
                fill(g, g + gl - 1, 1'b0);
            end
            r1 = window_release(16);
            if ($urandom_range(1, 0) == 1) begin
                d  = r1 - 1 + $urandom_range(40, 0);
                dl = $urandom_range(8, 1);
                fill(d, d + dl - 1, 1'b0);
                xl = d + 2;
                r2 = window_release(xl + 16);
                last = r2;
            end else begin
                xl = INF; r2 = INF;
                last = r1;
            end
            run_trial(last + 40);
        end

        // Lock never arrives: four pulses, then FAIL; then restart from FAIL.
        @(negedge clk);
        reset = 1'b1; pll_locked = 1'b0; restart = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 4 * TO_PERIOD + 8; n++) begin
            @(negedge clk);
            chk("timeout_pll_reset_a", n, 32'(pll_reset_a),
                (n >= 4 * TO_PERIOD) ? 32'd1 : (((n % TO_PERIOD) < 16) ? 32'd1 : 32'd0));
            chk("timeout_fail_a", n, 32'(fail_a), (n >= 4 * TO_PERIOD) ? 32'd1 : 32'd0);
            chk("timeout_rst_out_a", n, 32'(rst_out_a), 32'hF);
            chk("timeout_pll_reset_b", n, 32'(pll_reset_b),
                (n >= 4 * TO_PERIOD) ? 32'd1 : (((n % TO_PERIOD) < 16) ? 32'd1 : 32'd0));
            chk("timeout_fail_b", n, 32'(fail_b), (n >= 4 * TO_PERIOD) ? 32'd1 : 32'd0);
        end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_fail_a", 0, 32'(fail_a), 32'd0);
        chk("restart_pll_reset_a", 0, 32'(pll_reset_a), 32'd1);
        for (int j = 1; j <= TO_PERIOD + 18; j++) begin
            @(negedge clk);
            chk("restart_pll_reset_a", j, 32'(pll_reset_a), ((j % TO_PERIOD) < 16) ? 32'd1 : 32'd0);
            chk("restart_fail_a", j, 32'(fail_a), 32'd0);
            chk("restart_fail_b", j, 32'(fail_b), 32'd0);
            chk("restart_lost_a", j, 32'(lost_a), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
